mod_count_sequencer: RTL and testbench

MOD_COUNT_SEQUENCER -- requirements
Module: mod_count_sequencer

---
 rtl/mod_count_sequencer.sv | 120 ++++++++++++
 tb/tb_mod_count_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mod_count_sequencer.sv
// Modulo counter sequencer: counts 0..mod-1 for a configured number of wraps,
// with pause/abort control and a config handshake accepted only while idle.
module mod_count_sequencer #(
  parameter int unsigned DEFAULT_MOD = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_mod,
  input  logic [3:0] cfg_rounds,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [3:0] count_out,
  output logic       tc,
  output logic       busy,
  output logic       done
);
  localparam logic [3:0] DEF_MOD = DEFAULT_MOD[3:0];

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] mod_q, mod_d;
  logic [3:0] rounds_q, rounds_d;
  logic [3:0] rnd_q, rnd_d;
  logic [3:0] count_d;
  logic       tc_d, done_d, busy_d, ready_d;

  logic       at_tc, last_round, cfg_xfer;
  logic [3:0] rnd_inc;

  assign at_tc      = (count_out == mod_q - 4'd1);
  // Round counter saturates so a free-running sequence never wraps it
  assign rnd_inc    = (rnd_q == 4'hF) ? rnd_q : rnd_q + 4'd1;
  assign last_round = (rounds_q != 4'd0) && (rnd_inc == rounds_q);
  assign cfg_xfer   = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mod_q     <= DEF_MOD;
      rounds_q  <= 4'd1;
      rnd_q     <= 4'd0;
      count_out <= 4'd0;
      tc        <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      mod_q     <= mod_d;
      rounds_q  <= rounds_d;
      rnd_q     <= rnd_d;
      count_out <= count_d;
      tc        <= tc_d;
      done      <= done_d;
      busy      <= busy_d;
      cfg_ready <= ready_d;
    end
  end

  // Wrap/done takes precedence over pause; a pause seen at terminal count
  // still wraps, then parks in HOLD at zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (abort)      state_d = IDLE;
        else if (at_tc) state_d = last_round ? DONE : (pause ? HOLD : RUN);
        else if (pause) state_d = HOLD;
      end
      HOLD: begin
        if (abort)       state_d = IDLE;
        else if (!pause) state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_out;
    tc_d     = 1'b0;
    done_d   = 1'b0;
    rnd_d    = rnd_q;
    mod_d    = mod_q;
    rounds_d = rounds_q;
    case (state_q)
      IDLE: begin
        if (cfg_xfer) begin
          mod_d    = (cfg_mod < 4'd2) ? DEF_MOD : cfg_mod;
          rounds_d = cfg_rounds;
        end
        count_d = 4'd0;
        if (start) rnd_d = 4'd0;
      end
      RUN: begin
        if (abort) begin
          count_d = 4'd0;
        end else if (at_tc) begin
          count_d = 4'd0;
          tc_d    = 1'b1;
          rnd_d   = rnd_inc;
          done_d  = last_round;
        end else if (!pause) begin
          count_d = count_out + 4'd1;
        end
      end
      HOLD:    if (abort) count_d = 4'd0;
      DONE:    count_d = 4'd0;
      default: count_d = 4'd0;
    endcase
    busy_d  = (state_d == RUN) || (state_d == HOLD);
    ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_mod_count_sequencer.sv
// Self-checking bench: directed scenarios with literal checks plus randomized
// traffic, all compared every cycle against a behavioural model.
module tb_mod_count_sequencer;
  logic       clk = 1'b0;
  logic       rst, cfg_valid, start, pause, abort;
  logic [3:0] cfg_mod, cfg_rounds;
  logic       cfg_ready, tc, busy, done;
  logic [3:0] count_out;

  int tests = 0;
  int fails = 0;

  mod_count_sequencer #(.DEFAULT_MOD(12)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mod(cfg_mod), .cfg_rounds(cfg_rounds), .start(start), .pause(pause),
    .abort(abort), .count_out(count_out), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model: activity (0 idle, 1 counting, 2 paused, 3 finishing)
  int m_act = 0, m_cnt = 0, m_mod = 12, m_rounds = 1, m_wraps = 0;
  bit m_tc = 0, m_done = 0;

  task automatic model_edge();
    bit was_tc = 0, was_done = 0;
    if (rst) begin
      m_act = 0; m_cnt = 0; m_mod = 12; m_rounds = 1; m_wraps = 0;
    end else if (m_act == 0) begin
      if (cfg_valid) begin
        m_mod    = (cfg_mod < 2) ? 12 : int'(cfg_mod);
        m_rounds = int'(cfg_rounds);
      end
      m_cnt = 0;
      if (start) begin m_act = 1; m_wraps = 0; end
    end else if (m_act == 3) begin
      m_act = 0; m_cnt = 0;
    end else if (abort) begin
      m_act = 0; m_cnt = 0;
    end else if (m_act == 2) begin
      if (!pause) m_act = 1;
    end else if (m_cnt + 1 == m_mod) begin
      m_cnt  = 0;
      was_tc = 1;
      m_wraps = (m_wraps < 15) ? m_wraps + 1 : 15;
      if (m_rounds != 0 && m_wraps == m_rounds) begin
        m_act = 3; was_done = 1;
      end else m_act = pause ? 2 : 1;
    end else if (pause) m_act = 2;
    else m_cnt = m_cnt + 1;
    m_tc = was_tc; m_done = was_done;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("count_out", {4'd0, count_out}, 8'(m_cnt));
    chk("tc",        {7'd0, tc},        {7'd0, m_tc});
    chk("done",      {7'd0, done},      {7'd0, m_done});
    chk("busy",      {7'd0, busy},      {7'd0, (m_act == 1 || m_act == 2)});
    chk("cfg_ready", {7'd0, cfg_ready}, {7'd0, (m_act == 0)});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    rst = 0; cfg_valid = 0; start = 0; pause = 0; abort = 0;
    cfg_mod = 0; cfg_rounds = 0;
  endtask

  task automatic cfg_start(input logic [3:0] md, input logic [3:0] rn);
    cfg_valid = 1; cfg_mod = md; cfg_rounds = rn; start = 1;
    step();
    cfg_valid = 0; start = 0;
  endtask

  int ntc, ndone;

  initial begin
    idle_inputs();
    rst = 1;
    step(); step();
    chk("rst_count", {4'd0, count_out}, 8'd0);
    chk("rst_ready", {7'd0, cfg_ready}, 8'd1);
    chk("rst_busy",  {7'd0, busy},      8'd0);

    // Default config: one round of 0..11
    rst = 0; start = 1;
    step(); start = 0;
    chk("def_first", {4'd0, count_out}, 8'd0);
    for (int i = 0; i < 11; i++) step();
    chk("def_eleven", {4'd0, count_out}, 8'd11);
    step();
    chk("def_tc",   {7'd0, tc},   8'd1);
    chk("def_done", {7'd0, done}, 8'd1);
    step();
    chk("def_idle", {7'd0, cfg_ready}, 8'd1);

    // mod 5, 3 rounds, config and start together
    cfg_start(4'd5, 4'd3);
    ntc = 0; ndone = 0;
    for (int i = 0; i < 15; i++) begin
      step(); ntc += int'(tc); ndone += int'(done);
    end
    chk("m5_tcs",  8'(ntc),   8'd3);
    chk("m5_done", {7'd0, done}, 8'd1);
    chk("m5_ndone", 8'(ndone), 8'd1);
    step();
    chk("m5_busy_after", {7'd0, busy}, 8'd0);

    // Illegal mod -> default, free-run, then abort
    cfg_start(4'd1, 4'd0);
    ntc = 0; ndone = 0;
    for (int i = 0; i < 40; i++) begin
      step(); ntc += int'(tc); ndone += int'(done);
    end
    chk("free_tcs",  8'(ntc),   8'd3);
    chk("free_done", 8'(ndone), 8'd0);
    abort = 1; step(); abort = 0;
    chk("free_abort_cnt",  {4'd0, count_out}, 8'd0);
    chk("free_abort_busy", {7'd0, busy},      8'd0);

    // Pause at count 4 with mod 6
    cfg_start(4'd6, 4'd1);
    for (int i = 0; i < 4; i++) step();
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_cnt",  {4'd0, count_out}, 8'd4);
      chk("hold_busy", {7'd0, busy},      8'd1);
    end
    pause = 0;
    step();
    step();
    chk("resume5", {4'd0, count_out}, 8'd5);
    step();
    chk("resume_tc", {7'd0, tc}, 8'd1);
    step();

    // Abort in final wrap cycle; start during run is ignored
    cfg_start(4'd3, 4'd2);
    start = 1;
    for (int i = 0; i < 5; i++) step();
    start = 0;
    chk("pre_abort2", {4'd0, count_out}, 8'd2);
    abort = 1; step(); abort = 0;
    chk("abort_tc",   {7'd0, tc},        8'd0);
    chk("abort_done", {7'd0, done},      8'd0);
    chk("abort_idle", {7'd0, cfg_ready}, 8'd1);
    step();

    // Config ignored while busy, then reset mid-run
    cfg_start(4'd10, 4'd1);
    for (int i = 0; i < 6; i++) step();
    cfg_valid = 1; cfg_mod = 4'd3; cfg_rounds = 4'd2;
    #1 chk("busy_ready", {7'd0, cfg_ready}, 8'd0);
    step();
    chk("busy_cfg_cnt7", {4'd0, count_out}, 8'd7);
    cfg_valid = 0;
    rst = 1; step(); rst = 0;
    chk("mid_rst_cnt",   {4'd0, count_out}, 8'd0);
    chk("mid_rst_busy",  {7'd0, busy},      8'd0);
    chk("mid_rst_ready", {7'd0, cfg_ready}, 8'd1);
    cfg_start(4'd4, 4'd1);
    for (int i = 0; i < 3; i++) step();
    chk("post_rst_cnt3", {4'd0, count_out}, 8'd3);
    step();
    chk("post_rst_done", {7'd0, done}, 8'd1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_mod    = 4'($urandom_range(0, 15));
      cfg_rounds = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'($urandom_range(0, 3));
      start      = ($urandom_range(0, 2) == 0);
      pause      = ($urandom_range(0, 5) == 0);
      abort      = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
